// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: active-low level names,
// default geometry and the clear-engine state encoding.
package regfile_mp_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic {
    RF_CLR_IDLE  = 1'b0,
    RF_CLR_SWEEP = 1'b1
  } rf_clr_state_e;

endpackage

// File: rtl/regfile_mp_clr_ctrl.sv
// Clear engine: on a request seen in IDLE, walks ptr from 0 to DEPTH-1 issuing
// one zeroing write per cycle, with busy held high for the whole sweep.
module regfile_mp_clr_ctrl
  import regfile_mp_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              clr_,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  rf_clr_state_e     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              clr_req;

  assign clr_req = (clr_ != DISABLE_);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      RF_CLR_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLR_SWEEP;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RF_CLR_SWEEP: begin
        // Requests arriving mid-sweep are neither restarted nor queued.
        if (ptr_q == LAST_PTR) begin
          state_d = RF_CLR_IDLE;
          ptr_d   = '0;
          busy_d  = 1'b0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = RF_CLR_IDLE;
        ptr_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q <= RF_CLR_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign clr_we   = (state_q == RF_CLR_SWEEP);
  assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// General-purpose register file: two combinational read ports with optional
// write bypass, one write port, optional hardwired-zero entry 0, sequential clear.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [DATA_W-1:0] rd0_data,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  input  logic              we_,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_,
  output logic              busy
);

  // One extra bit so DEPTH itself is representable when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] ff [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;

  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_X) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  regfile_mp_clr_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_ctrl (
    .clk      (clk),
    .reset_   (reset_),
    .clr_     (clr_),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_ok = (we_ == ENABLE_) && !busy && addr_live(wr_addr);

  // Array write priority: reset, then sweep, then external write.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++) begin
        ff[i] <= '0;
      end
    end else if (clr_we) begin
      ff[clr_addr] <= '0;
    end else if (wr_ok) begin
      ff[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd0_data = '0;
    if (addr_live(rd0_addr)) begin
      rd0_data = ff[rd0_addr];
    end
    if ((BYPASS != 0) && wr_ok && (wr_addr == rd0_addr)) begin
      rd0_data = wr_data;
    end
  end

  always_comb begin
    rd1_data = '0;
    if (addr_live(rd1_addr)) begin
      rd1_data = ff[rd1_addr];
    end
    if ((BYPASS != 0) && wr_ok && (wr_addr == rd1_addr)) begin
      rd1_data = wr_data;
    end
  end

endmodule
